// File: rtl/mbscore_alu_arbiter.sv
// mbscore_alu_arbiter: round-robin sharing of one MBScore ALU between NUM_REQ requesters.
// Optional statistics counters (stat_ops, stat_wait) are enabled by defining
// MBSCORE_ALU_ARB_STATS_EN.
module mbscore_alu_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OP_WIDTH    = 5,
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [OP_WIDTH-1:0] NOP_OP = OP_WIDTH'(5'h1F)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           resp_cf,
    output logic [DATA_WIDTH-1:0]          alu_in_a,
    output logic [DATA_WIDTH-1:0]          alu_in_b,
    output logic [OP_WIDTH-1:0]            alu_op_type,
    input  logic [DATA_WIDTH-1:0]          alu_out,
    input  logic                           alu_cf,
    output logic                           busy
`ifdef MBSCORE_ALU_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_ops,
    output logic [31:0]                    stat_wait
`endif
);

    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [GNT_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [GNT_W-1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]     alu_op_q, alu_op_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_cf_q, resp_cf_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   a_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr  [NUM_REQ];
    logic [OP_WIDTH-1:0]     op_arr [NUM_REQ];
    logic                    win_found;
    logic [GNT_W-1:0]        win_idx;
    logic [GNT_W-1:0]        scan_idx;

    // Unpack the flattened request buses into per-requester arrays
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i]  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_arr[i]  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            op_arr[i] = req_op[i*OP_WIDTH +: OP_WIDTH];
        end
    end

    // Round-robin winner: first valid requester scanning upward from rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = GNT_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_cf_d    = resp_cf_q;
        req_ready    = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d  = win_idx;
                    alu_a_d  = a_arr[win_idx];
                    alu_b_d  = b_arr[win_idx];
                    alu_op_d = op_arr[win_idx];
                    cnt_d    = CNT_W'(ALU_LATENCY);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    resp_data_d           = alu_out;
                    resp_cf_d             = alu_cf;
                    alu_op_d              = NOP_OP;
                    resp_valid_d[grant_q] = 1'b1;
                    state_d               = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[grant_q]) begin
                    resp_valid_d = '0;
                    rr_ptr_d     = (grant_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_q + GNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= NOP_OP;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_cf_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_cf_q    <= resp_cf_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_cf     = resp_cf_q;
    assign alu_in_a    = alu_a_q;
    assign alu_in_b    = alu_b_q;
    assign alu_op_type = alu_op_q;
    assign busy        = busy_q;

`ifdef MBSCORE_ALU_ARB_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_wait_q, stat_wait_d;

    // Completed-handshake and requester-stall counters, wrapping at 2^32
    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_wait_d = stat_wait_q;
        if (state_q == ST_RESP && resp_ready[grant_q]) begin
            stat_ops_d = stat_ops_q + 32'd1;
        end
        if (|(req_valid & ~req_ready)) begin
            stat_wait_d = stat_wait_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_wait_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_wait_q <= stat_wait_d;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_wait = stat_wait_q;
`endif

endmodule

// File: tb/tb_mbscore_alu_arbiter.sv
// Directed testbench for mbscore_alu_arbiter (NUM_REQ=2). One instance with ALU_LATENCY=1,
// one with ALU_LATENCY=3 for the mid-operation reset case. Statistics checks are active when
// MBSCORE_ALU_ARB_STATS_EN is defined.
module tb_mbscore_alu_arbiter;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_NOP = 5'h1F;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst3;
    logic [1:0]  req_valid;
    logic [1:0]  req_valid3;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_op;
    logic [1:0]  resp_ready;

    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_data, alu_in_a, alu_in_b, alu_out;
    logic        resp_cf, alu_cf, busy;
    logic [4:0]  alu_op_type;

    logic [1:0]  req_ready3, resp_valid3;
    logic [31:0] resp_data3, alu_in_a3, alu_in_b3, alu_out3;
    logic        resp_cf3, alu_cf3, busy3;
    logic [4:0]  alu_op_type3;

`ifdef MBSCORE_ALU_ARB_STATS_EN
    logic [31:0] stat_ops, stat_wait, stat_ops3, stat_wait3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            default: return 33'd0;
        endcase
    endfunction

    assign {alu_cf, alu_out}   = alu_f(alu_in_a, alu_in_b, alu_op_type);
    assign {alu_cf3, alu_out3} = alu_f(alu_in_a3, alu_in_b3, alu_op_type3);

    mbscore_alu_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .OP_WIDTH(5), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_cf(resp_cf),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op_type(alu_op_type),
        .alu_out(alu_out), .alu_cf(alu_cf), .busy(busy)
`ifdef MBSCORE_ALU_ARB_STATS_EN
        , .stat_ops(stat_ops), .stat_wait(stat_wait)
`endif
    );

    mbscore_alu_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .OP_WIDTH(5), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid3), .resp_ready(resp_ready),
        .resp_data(resp_data3), .resp_cf(resp_cf3),
        .alu_in_a(alu_in_a3), .alu_in_b(alu_in_b3), .alu_op_type(alu_op_type3),
        .alu_out(alu_out3), .alu_cf(alu_cf3), .busy(busy3)
`ifdef MBSCORE_ALU_ARB_STATS_EN
        , .stat_ops(stat_ops3), .stat_wait(stat_wait3)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_op[i*5 +: 5]  = op;
    endtask

    initial begin
        int          k [2];
        int          g;
        int          exp_wait;
        logic [1:0]  expg;
        logic [31:0] exp_data;

        rst = 1'b1; rst3 = 1'b1;
        req_valid = '0; req_valid3 = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (3) step();

        // reset state
        chk("rst_req_ready",  64'(req_ready),   64'd0);
        chk("rst_resp_valid", 64'(resp_valid),  64'd0);
        chk("rst_resp_data",  64'(resp_data),   64'd0);
        chk("rst_resp_cf",    64'(resp_cf),     64'd0);
        chk("rst_alu_a",      64'(alu_in_a),    64'd0);
        chk("rst_alu_b",      64'(alu_in_b),    64'd0);
        chk("rst_alu_op",     64'(alu_op_type), 64'(OP_NOP));
        chk("rst_busy",       64'(busy),        64'd0);
        rst = 1'b0;
        step();

        // r0 ADD 5+7
        set_req(0, 32'd5, 32'd7, OP_ADD);
        req_valid = 2'b01; resp_ready = 2'b01;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'h1);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        step();
        req_valid = 2'b00;
        #1;
        chk("t1_exec_busy",  64'(busy),        64'd1);
        chk("t1_exec_ready", 64'(req_ready),   64'd0);
        chk("t1_alu_a",      64'(alu_in_a),    64'd5);
        chk("t1_alu_b",      64'(alu_in_b),    64'd7);
        chk("t1_alu_op",     64'(alu_op_type), 64'(OP_ADD));
        chk("t1_exec_rv",    64'(resp_valid),  64'd0);
        step();
        chk("t1_resp_valid", 64'(resp_valid),  64'h1);
        chk("t1_resp_data",  64'(resp_data),   64'd12);
        chk("t1_resp_cf",    64'(resp_cf),     64'd0);
        chk("t1_resp_op",    64'(alu_op_type), 64'(OP_NOP));
        step();
        chk("t1_busy_fall",  64'(busy),        64'd0);
        chk("t1_rv_clear",   64'(resp_valid),  64'd0);
        chk("t1_data_hold",  64'(resp_data),   64'd12);

        // r1 SUB 0-1 (rr_ptr now 1)
        set_req(1, 32'd0, 32'd1, OP_SUB);
        req_valid = 2'b10; resp_ready = 2'b10;
        #1;
        chk("t3_req_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        step();
        chk("t3_resp_valid", 64'(resp_valid), 64'h2);
        chk("t3_resp_data",  64'(resp_data),  64'hFFFF_FFFF);
        chk("t3_resp_cf",    64'(resp_cf),    64'd1);
        step();
        chk("t3_busy_fall",  64'(busy),       64'd0);

        // both requesters continuously valid, 4 ops each, from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        k[0] = 0; k[1] = 0; exp_wait = 0;
        set_req(0, 32'd10, 32'd100, OP_ADD);
        set_req(1, 32'd20, 32'd200, OP_ADD);
        req_valid = 2'b11; resp_ready = 2'b11;
        #1;
        for (int op = 0; op < 8; op++) begin
            g        = op % 2;
            expg     = 2'(1 << g);
            exp_data = 32'((g + 1) * 110 + k[g]);
            chk("t2_grant", 64'(req_ready), 64'(expg));
            if (|(req_valid & ~expg)) exp_wait++;
            step();
            k[g]++;
            if (k[g] == 4) req_valid[g] = 1'b0;
            else set_req(g, 32'((g + 1) * 10 + k[g]), 32'((g + 1) * 100), OP_ADD);
            #1;
            chk("t2_exec_ready", 64'(req_ready), 64'd0);
            if (|req_valid) exp_wait++;
            step();
            chk("t2_resp_valid", 64'(resp_valid), 64'(expg));
            chk("t2_resp_data",  64'(resp_data),  64'(exp_data));
            if (|req_valid) exp_wait++;
            step();
        end
        chk("t2_idle_busy", 64'(busy), 64'd0);
`ifdef MBSCORE_ALU_ARB_STATS_EN
        chk("t6_stat_ops",  64'(stat_ops),  64'd8);
        chk("t6_stat_wait", 64'(stat_wait), 64'(exp_wait));
`endif

        // response back-pressure on r0 while r1 is waiting
        set_req(0, 32'd3, 32'd4, OP_ADD);
        req_valid = 2'b01; resp_ready = 2'b00;
        #1;
        chk("t4_req_ready", 64'(req_ready), 64'h1);
        step();
        set_req(1, 32'd9, 32'd2, OP_SUB);
        req_valid = 2'b10;
        #1;
        chk("t4_exec_ready", 64'(req_ready), 64'd0);
        step();
        for (int c = 0; c < 5; c++) begin
            resp_ready = 2'b10;
            #1;
            chk("t4_hold_valid", 64'(resp_valid), 64'h1);
            chk("t4_hold_data",  64'(resp_data),  64'd7);
            chk("t4_hold_ready", 64'(req_ready),  64'd0);
            step();
        end
        resp_ready = 2'b01;
        #1;
        chk("t4_last_valid", 64'(resp_valid), 64'h1);
        step();
        chk("t4_r1_accept",  64'(req_ready),  64'h2);
        chk("t4_rv_clear",   64'(resp_valid), 64'd0);
        chk("t4_data_kept",  64'(resp_data),  64'd7);
        resp_ready = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        chk("t4_r1_valid",   64'(resp_valid), 64'h2);
        chk("t4_r1_data",    64'(resp_data),  64'd7);
        chk("t4_r1_cf",      64'(resp_cf),    64'd0);
        step();
        chk("t4_busy_fall",  64'(busy),       64'd0);

        // latency-3 instance: one full op, then reset in the middle of a second
        rst3 = 1'b0;
        set_req(0, 32'd1, 32'd1, OP_ADD);
        req_valid3 = 2'b01; resp_ready = 2'b01;
        #1;
        chk("t5_req_ready", 64'(req_ready3), 64'h1);
        step();
        req_valid3 = 2'b00;
        step(); step();
        chk("t5_not_yet",   64'(resp_valid3), 64'd0);
        step();
        chk("t5_resp_valid", 64'(resp_valid3), 64'h1);
        chk("t5_resp_data",  64'(resp_data3),  64'd2);
        step();
        set_req(0, 32'd40, 32'd2, OP_ADD);
        req_valid3 = 2'b01;
        #1;
        chk("t5_req_ready2", 64'(req_ready3), 64'h1);
        step();
        req_valid3 = 2'b00;
        step();
        chk("t5_exec_busy", 64'(busy3), 64'd1);
        rst3 = 1'b1;
        step();
        chk("t5_rst_rv",    64'(resp_valid3),  64'd0);
        chk("t5_rst_busy",  64'(busy3),        64'd0);
        chk("t5_rst_op",    64'(alu_op_type3), 64'(OP_NOP));
        chk("t5_rst_a",     64'(alu_in_a3),    64'd0);
        chk("t5_rst_b",     64'(alu_in_b3),    64'd0);
        chk("t5_rst_data",  64'(resp_data3),   64'd0);
        chk("t5_rst_cf",    64'(resp_cf3),     64'd0);
        chk("t5_rst_ready", 64'(req_ready3),   64'd0);
        rst3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_no_resp", 64'(resp_valid3), 64'd0);
        end
        req_valid3 = 2'b11;
        #1;
        chk("t5_rr_reset", 64'(req_ready3), 64'h1);
        step();
        req_valid3 = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
